// File: rtl/dispatch_decoder_pkg.sv
// Shared RV32I decode constants, dispatch unit encodings and immediate helpers
// for the dispatch_decoder slice.
package dispatch_decoder_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] UNIT_ROB = 2'd0;
  localparam logic [1:0] UNIT_RS  = 2'd1;
  localparam logic [1:0] UNIT_LSB = 2'd2;

  localparam logic [31:0] HALT_INST = 32'h0ff00513;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/dispatch_decoder_inst_queue.sv
// Circular instruction FIFO with combinational head, global enable and a
// clear that overrides push and pop.
module inst_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = en && !clear && push && !full;
  assign do_pop  = en && !clear && pop && !empty;

  assign head_valid = !empty;
  assign head_data  = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (en) begin
      if (clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

endmodule

// File: rtl/dispatch_decoder.sv
// RV32I decode/dispatch stage: queue head decode, rename bypass, registered
// dispatch outputs and fetch redirect. Optional macro: BRANCH_PREDICT_BTFN_EN.
module dispatch_decoder #(
  parameter int          ROB_W     = 5,
  parameter int          IQ_DEPTH  = 4,
  parameter logic [31:0] HALT_INST = dispatch_decoder_pkg::HALT_INST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_inst,
  output logic             fetch_ready,
  output logic [4:0]       rf_rs1_idx,
  output logic [4:0]       rf_rs2_idx,
  input  logic [31:0]      rf_rs1_val,
  input  logic [31:0]      rf_rs2_val,
  input  logic             rf_rs1_busy,
  input  logic             rf_rs2_busy,
  input  logic [ROB_W-1:0] rf_rs1_tag,
  input  logic [ROB_W-1:0] rf_rs2_tag,
  input  logic             rob_full,
  input  logic [ROB_W-1:0] rob_tail,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             disp_valid,
  output logic [1:0]       disp_unit,
  output logic [6:0]       disp_opcode,
  output logic [2:0]       disp_funct3,
  output logic             disp_funct7b5,
  output logic [4:0]       disp_rd,
  output logic             disp_rd_we,
  output logic [31:0]      disp_v1,
  output logic [31:0]      disp_v2,
  output logic [ROB_W-1:0] disp_q1,
  output logic [ROB_W-1:0] disp_q2,
  output logic             disp_has_q1,
  output logic             disp_has_q2,
  output logic [31:0]      disp_imm,
  output logic [31:0]      disp_pc,
  output logic [ROB_W-1:0] disp_rob_id,
  output logic             disp_pred_taken,
  output logic             disp_halt,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
);

  import dispatch_decoder_pkg::*;

  iq_entry_t        head;
  logic [63:0]      head_bits;
  logic             head_valid;
  logic             iq_full;
  logic             iq_clear;

  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic             is_halt, is_op, is_op_imm, is_branch, is_load, is_store;
  logic             is_jal, is_jalr, is_lui, is_auipc;
  logic             needs_rs, needs_lsb, can_disp, do_disp;
  logic             uses_rs1, uses_rs2, byp1, byp2;
  logic             pred_taken, take_redirect;
  logic [31:0]      redirect_target;

  logic [1:0]       unit_next;
  logic             rd_we_next;
  logic [31:0]      imm_next, v1_next, v2_next;
  logic [ROB_W-1:0] q1_next, q2_next;
  logic             has_q1_next, has_q2_next;

  logic             disp_valid_reg, redirect_valid_reg;
  logic [1:0]       disp_unit_reg;
  logic [6:0]       disp_opcode_reg;
  logic [2:0]       disp_funct3_reg;
  logic             disp_funct7b5_reg;
  logic [4:0]       disp_rd_reg;
  logic             disp_rd_we_reg;
  logic [31:0]      disp_v1_reg, disp_v2_reg, disp_imm_reg, disp_pc_reg;
  logic [ROB_W-1:0] disp_q1_reg, disp_q2_reg, disp_rob_id_reg;
  logic             disp_has_q1_reg, disp_has_q2_reg;
  logic             disp_pred_taken_reg, disp_halt_reg;
  logic [31:0]      redirect_pc_reg;

  inst_queue #(
    .WIDTH ($bits(iq_entry_t)),
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk        (clk),
    .rst        (rst),
    .en         (rdy),
    .clear      (iq_clear),
    .push       (fetch_valid),
    .push_data  ({fetch_pc, fetch_inst}),
    .pop        (can_disp),
    .head_valid (head_valid),
    .head_data  (head_bits),
    .full       (iq_full)
  );

  assign head        = iq_entry_t'(head_bits);
  assign fetch_ready = !iq_full;

  assign opcode = head.inst[6:0];
  assign rd     = head.inst[11:7];
  assign funct3 = head.inst[14:12];
  assign rs1    = head.inst[19:15];
  assign rs2    = head.inst[24:20];

  assign rf_rs1_idx = head_valid ? rs1 : 5'd0;
  assign rf_rs2_idx = head_valid ? rs2 : 5'd0;

  assign is_halt   = (head.inst == HALT_INST);
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);

  assign needs_rs  = !is_halt && (is_op || is_op_imm || is_branch);
  assign needs_lsb = !is_halt && (is_load || is_store);
  assign can_disp  = head_valid && !rob_full &&
                     !(needs_rs && rs_full) && !(needs_lsb && lsb_full);
  assign do_disp   = rdy && !flush && can_disp;

  assign uses_rs1 = is_op || is_op_imm || is_branch || is_load || is_store || is_jalr;
  assign uses_rs2 = is_op || is_branch || is_store;

  // The instruction dispatched last cycle has not reached the register file's
  // rename table yet, so its rd must be matched here.
  assign byp1 = disp_valid_reg && disp_rd_we_reg && (disp_rd_reg == rs1);
  assign byp2 = disp_valid_reg && disp_rd_we_reg && (disp_rd_reg == rs2);

`ifdef BRANCH_PREDICT_BTFN_EN
  assign pred_taken = is_branch && !is_halt && imm_b(head.inst)[31];
`else
  assign pred_taken = 1'b0;
`endif

  assign take_redirect   = is_jal || pred_taken;
  assign redirect_target = head.pc + (is_jal ? imm_j(head.inst) : imm_b(head.inst));
  assign iq_clear        = flush || (do_disp && take_redirect);

  always_comb begin
    unit_next = UNIT_ROB;
    if (!is_halt) begin
      if (is_op || is_op_imm || is_branch) unit_next = UNIT_RS;
      else if (is_load || is_store)        unit_next = UNIT_LSB;
    end

    rd_we_next = (rd != 5'd0) && !is_branch && !is_store;

    imm_next = 32'd0;
    if (is_lui)                        imm_next = imm_u(head.inst);
    else if (is_auipc)                 imm_next = head.pc + imm_u(head.inst);
    else if (is_jal || is_jalr)        imm_next = head.pc + 32'd4;
    else if (is_branch)                imm_next = imm_b(head.inst);
    else if (is_store)                 imm_next = imm_s(head.inst);
    else if (is_load || is_op_imm)     imm_next = imm_i(head.inst);

    has_q1_next = 1'b0;
    q1_next     = '0;
    v1_next     = 32'd0;
    if (uses_rs1) begin
      if (byp1) begin
        has_q1_next = 1'b1;
        q1_next     = disp_rob_id_reg;
      end else if (rf_rs1_busy) begin
        has_q1_next = 1'b1;
        q1_next     = rf_rs1_tag;
      end else begin
        v1_next = rf_rs1_val;
      end
    end

    has_q2_next = 1'b0;
    q2_next     = '0;
    v2_next     = 32'd0;
    if (is_op_imm) begin
      // Shifts carry the shift amount; bit 30 in the immediate field is funct7.
      if (funct3 == 3'b001 || funct3 == 3'b101) v2_next = {27'd0, rs2};
      else                                     v2_next = imm_i(head.inst);
    end else if (uses_rs2) begin
      if (byp2) begin
        has_q2_next = 1'b1;
        q2_next     = disp_rob_id_reg;
      end else if (rf_rs2_busy) begin
        has_q2_next = 1'b1;
        q2_next     = rf_rs2_tag;
      end else begin
        v2_next = rf_rs2_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid_reg      <= 1'b0;
      redirect_valid_reg  <= 1'b0;
      redirect_pc_reg     <= 32'd0;
      disp_unit_reg       <= 2'd0;
      disp_opcode_reg     <= 7'd0;
      disp_funct3_reg     <= 3'd0;
      disp_funct7b5_reg   <= 1'b0;
      disp_rd_reg         <= 5'd0;
      disp_rd_we_reg      <= 1'b0;
      disp_v1_reg         <= 32'd0;
      disp_v2_reg         <= 32'd0;
      disp_q1_reg         <= '0;
      disp_q2_reg         <= '0;
      disp_has_q1_reg     <= 1'b0;
      disp_has_q2_reg     <= 1'b0;
      disp_imm_reg        <= 32'd0;
      disp_pc_reg         <= 32'd0;
      disp_rob_id_reg     <= '0;
      disp_pred_taken_reg <= 1'b0;
      disp_halt_reg       <= 1'b0;
    end else if (rdy) begin
      disp_valid_reg     <= do_disp;
      redirect_valid_reg <= do_disp && take_redirect;
      if (do_disp) begin
        if (take_redirect) redirect_pc_reg <= redirect_target;
        disp_unit_reg       <= unit_next;
        disp_opcode_reg     <= opcode;
        disp_funct3_reg     <= funct3;
        disp_funct7b5_reg   <= head.inst[30];
        disp_rd_reg         <= rd;
        disp_rd_we_reg      <= rd_we_next;
        disp_v1_reg         <= v1_next;
        disp_v2_reg         <= v2_next;
        disp_q1_reg         <= q1_next;
        disp_q2_reg         <= q2_next;
        disp_has_q1_reg     <= has_q1_next;
        disp_has_q2_reg     <= has_q2_next;
        disp_imm_reg        <= imm_next;
        disp_pc_reg         <= head.pc;
        disp_rob_id_reg     <= rob_tail;
        disp_pred_taken_reg <= pred_taken;
        disp_halt_reg       <= is_halt;
      end
    end
  end

  assign disp_valid      = disp_valid_reg && rdy;
  assign redirect_valid  = redirect_valid_reg && rdy;
  assign redirect_pc     = redirect_pc_reg;
  assign disp_unit       = disp_unit_reg;
  assign disp_opcode     = disp_opcode_reg;
  assign disp_funct3     = disp_funct3_reg;
  assign disp_funct7b5   = disp_funct7b5_reg;
  assign disp_rd         = disp_rd_reg;
  assign disp_rd_we      = disp_rd_we_reg;
  assign disp_v1         = disp_v1_reg;
  assign disp_v2         = disp_v2_reg;
  assign disp_q1         = disp_q1_reg;
  assign disp_q2         = disp_q2_reg;
  assign disp_has_q1     = disp_has_q1_reg;
  assign disp_has_q2     = disp_has_q2_reg;
  assign disp_imm        = disp_imm_reg;
  assign disp_pc         = disp_pc_reg;
  assign disp_rob_id     = disp_rob_id_reg;
  assign disp_pred_taken = disp_pred_taken_reg;
  assign disp_halt       = disp_halt_reg;

endmodule

// File: tb/tb_dispatch_decoder.sv
// Directed bench for dispatch_decoder: decode, bypass, JAL redirect,
// back-pressure, flush, branch prediction, halt and rdy freeze.
module tb_dispatch_decoder;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc, fetch_inst;
  logic        fetch_ready;
  logic [4:0]  rf_rs1_idx, rf_rs2_idx;
  logic [31:0] rf_rs1_val, rf_rs2_val;
  logic        rf_rs1_busy, rf_rs2_busy;
  logic [4:0]  rf_rs1_tag, rf_rs2_tag;
  logic        rob_full, rs_full, lsb_full;
  logic [4:0]  rob_tail;
  logic        disp_valid;
  logic [1:0]  disp_unit;
  logic [6:0]  disp_opcode;
  logic [2:0]  disp_funct3;
  logic        disp_funct7b5;
  logic [4:0]  disp_rd;
  logic        disp_rd_we;
  logic [31:0] disp_v1, disp_v2;
  logic [4:0]  disp_q1, disp_q2;
  logic        disp_has_q1, disp_has_q2;
  logic [31:0] disp_imm, disp_pc;
  logic [4:0]  disp_rob_id;
  logic        disp_pred_taken, disp_halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

`ifdef BRANCH_PREDICT_BTFN_EN
  localparam logic [31:0] EXP_PRED = 32'd1;
`else
  localparam logic [31:0] EXP_PRED = 32'd0;
`endif

  // Register file model: x0 reads 0, xN reads 0x1000+N.
  assign rf_rs1_val = (rf_rs1_idx == 5'd0) ? 32'd0 : 32'h1000 + {27'd0, rf_rs1_idx};
  assign rf_rs2_val = (rf_rs2_idx == 5'd0) ? 32'd0 : 32'h1000 + {27'd0, rf_rs2_idx};

  always #5 clk = ~clk;

  dispatch_decoder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_ready(fetch_ready),
    .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
    .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .rf_rs1_busy(rf_rs1_busy), .rf_rs2_busy(rf_rs2_busy),
    .rf_rs1_tag(rf_rs1_tag), .rf_rs2_tag(rf_rs2_tag),
    .rob_full(rob_full), .rob_tail(rob_tail), .rs_full(rs_full), .lsb_full(lsb_full),
    .disp_valid(disp_valid), .disp_unit(disp_unit), .disp_opcode(disp_opcode),
    .disp_funct3(disp_funct3), .disp_funct7b5(disp_funct7b5),
    .disp_rd(disp_rd), .disp_rd_we(disp_rd_we),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_has_q1(disp_has_q1), .disp_has_q2(disp_has_q2),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_id(disp_rob_id),
    .disp_pred_taken(disp_pred_taken), .disp_halt(disp_halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_inst  = inst;
    tick();
    fetch_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    fetch_valid = 1'b0; fetch_pc = 32'd0; fetch_inst = 32'd0;
    rf_rs1_busy = 1'b0; rf_rs2_busy = 1'b0; rf_rs1_tag = 5'd0; rf_rs2_tag = 5'd0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tail = 5'd3;
    tick(); tick();
    check("rst_disp_valid", disp_valid, 0);
    check("rst_fetch_ready", fetch_ready, 1);
    check("rst_redirect", redirect_valid, 0);
    check("rst_rob_id", disp_rob_id, 0);
    rst = 1'b0;
    tick();

    // addi x1,x0,5 then add x2,x1,x1 back to back
    fetch_valid = 1'b1; fetch_pc = 32'h0; fetch_inst = 32'h00500093;
    tick();
    check("addi_not_yet", disp_valid, 0);
    fetch_pc = 32'h4; fetch_inst = 32'h00108133;
    tick();
    fetch_valid = 1'b0;
    check("addi_valid", disp_valid, 1);
    check("addi_unit", disp_unit, 1);
    check("addi_v2", disp_v2, 5);
    check("addi_rd", disp_rd, 1);
    check("addi_rob_id", disp_rob_id, 3);
    check("addi_has_q1", disp_has_q1, 0);
    check("addi_rd_we", disp_rd_we, 1);
    rob_tail = 5'd4;
    tick();
    check("add_valid", disp_valid, 1);
    check("add_rd", disp_rd, 2);
    check("add_has_q1", disp_has_q1, 1);
    check("add_has_q2", disp_has_q2, 1);
    check("add_q1", disp_q1, 3);
    check("add_q2", disp_q2, 3);
    check("add_rob_id", disp_rob_id, 4);
    tick();
    check("pulse_one_cycle", disp_valid, 0);

    // jal x0,-8 at 0x100 with two younger entries; push in redirect cycle dropped
    rob_full = 1'b1;
    push(32'h100, 32'hff9ff06f);
    push(32'h104, 32'h00108133);
    push(32'h108, 32'h00108133);
    check("jal_held", disp_valid, 0);
    rob_full = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'h10c; fetch_inst = 32'h00108133;
    tick();
    fetch_valid = 1'b0;
    check("jal_valid", disp_valid, 1);
    check("jal_redirect", redirect_valid, 1);
    check("jal_redirect_pc", redirect_pc, 32'hf8);
    check("jal_imm", disp_imm, 32'h104);
    check("jal_rd_we", disp_rd_we, 0);
    check("jal_unit", disp_unit, 0);
    check("jal_q_empty_idx", rf_rs1_idx, 0);
    tick();
    check("jal_after_valid", disp_valid, 0);
    check("jal_after_redirect", redirect_valid, 0);
    tick();
    check("jal_q_drained", disp_valid, 0);

    // four loads held by lsb_full, then drained in order
    lsb_full = 1'b1;
    push(32'h200, 32'h00002283);
    push(32'h204, 32'h00402303);
    push(32'h208, 32'h00802383);
    push(32'h20c, 32'hffc02403);
    check("iq_full_ready", fetch_ready, 0);
    check("lsb_block", disp_valid, 0);
    lsb_full = 1'b0;
    tick();
    check("ld0_valid", disp_valid, 1);
    check("ld0_rd", disp_rd, 5);
    check("ld0_unit", disp_unit, 2);
    check("ld0_v1", disp_v1, 0);
    check("ld0_ready_again", fetch_ready, 1);
    tick();
    check("ld1_rd", disp_rd, 6);
    check("ld1_imm", disp_imm, 4);
    tick();
    check("ld2_rd", disp_rd, 7);
    tick();
    check("ld3_rd", disp_rd, 8);
    check("ld3_imm", disp_imm, 32'hfffffffc);
    tick();
    check("ld_done", disp_valid, 0);

    // flush with a full queue, a push offered and the ROB becoming free
    rob_full = 1'b1;
    push(32'h300, 32'h00108133);
    push(32'h304, 32'h00108133);
    push(32'h308, 32'h00108133);
    push(32'h30c, 32'h00108133);
    check("flush_pre_full", fetch_ready, 0);
    flush = 1'b1; rob_full = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'h310; fetch_inst = 32'h00108133;
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    check("flush_valid", disp_valid, 0);
    check("flush_ready", fetch_ready, 1);
    check("flush_idx", rf_rs1_idx, 0);
    tick();
    check("flush_empty", disp_valid, 0);

    // beq x0,x0,-16 at 0x40
    push(32'h40, 32'hfe0008e3);
    tick();
    check("beq_valid", disp_valid, 1);
    check("beq_unit", disp_unit, 1);
    check("beq_imm", disp_imm, 32'hfffffff0);
    check("beq_rd_we", disp_rd_we, 0);
    check("beq_pred", disp_pred_taken, EXP_PRED);
    check("beq_redirect", redirect_valid, EXP_PRED);
`ifdef BRANCH_PREDICT_BTFN_EN
    check("beq_redirect_pc", redirect_pc, 32'h30);
`endif
    tick();

    // halt
    push(32'h50, 32'h0ff00513);
    tick();
    check("halt_valid", disp_valid, 1);
    check("halt_flag", disp_halt, 1);
    check("halt_unit", disp_unit, 0);

    // srai x3,x1,3 with rs1 pending in the RF
    rf_rs1_busy = 1'b1; rf_rs1_tag = 5'd9;
    push(32'h54, 32'h4030d193);
    tick();
    rf_rs1_busy = 1'b0;
    check("srai_v2", disp_v2, 3);
    check("srai_f7b5", disp_funct7b5, 1);
    check("srai_has_q1", disp_has_q1, 1);
    check("srai_q1", disp_q1, 9);
    check("srai_halt", disp_halt, 0);

    // auipc x4,0x12345 at 0x200
    push(32'h200, 32'h12345217);
    tick();
    check("auipc_imm", disp_imm, 32'h12345200);
    check("auipc_unit", disp_unit, 0);
    check("auipc_rd", disp_rd, 4);

    // lui x6,0xabcde held while rdy is low
    push(32'h204, 32'habcde337);
    rdy = 1'b0;
    tick();
    check("rdy_low_hold", disp_valid, 0);
    rdy = 1'b1;
    tick();
    check("lui_valid", disp_valid, 1);
    check("lui_imm", disp_imm, 32'habcde000);
    rdy = 1'b0;
    #1;
    check("rdy_gate", disp_valid, 0);
    rdy = 1'b1;
    tick();
    tick();
    check("final_idle", disp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_decoder.md
Name: dispatch_decoder

Overview:
Second-generation decode/dispatch stage sitting between instruction fetch and the ROB, reservation station (RS) and load/store buffer (LSB).
- Buffers fetched instructions in a parametrised queue and decodes RV32I at the head.
- Reads operand state from the register file and dispatches at most one instruction per cycle through a registered output stage.
- Bypasses renaming for back-to-back dependences.
- Redirects fetch on JAL and, optionally, on predicted-taken branches.

Parameters:
ROB_W, 5, ROB index width; ROB depth is 2**ROB_W.
IQ_DEPTH, 4, instruction queue entries; power of two, at least 2.
HALT_INST, 32'h0ff00513, encoding that marks program exit.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; low freezes all state
flush  in  1  ROB misprediction flush
fetch_valid  in  1  fetch offers an instruction
fetch_pc  in  32  PC of the offered instruction
fetch_inst  in  32  offered instruction word
fetch_ready  out  1  queue can accept
rf_rs1_idx  out  5  head rs1 index (combinational)
rf_rs2_idx  out  5  head rs2 index (combinational)
rf_rs1_val  in  32  register value for rs1
rf_rs2_val  in  32  register value for rs2
rf_rs1_busy  in  1  rs1 has a pending producer
rf_rs2_busy  in  1  rs2 has a pending producer
rf_rs1_tag  in  ROB_W  ROB id of the rs1 producer
rf_rs2_tag  in  ROB_W  ROB id of the rs2 producer
rob_full  in  1  ROB cannot accept
rob_tail  in  ROB_W  ROB id the next dispatch receives
rs_full  in  1  RS cannot accept
lsb_full  in  1  LSB cannot accept
disp_valid  out  1  one-cycle dispatch pulse
disp_unit  out  2  0 = ROB only, 1 = RS, 2 = LSB
disp_opcode  out  7  instruction opcode
disp_funct3  out  3  instruction funct3
disp_funct7b5  out  1  instruction bit 30
disp_rd  out  5  destination register
disp_rd_we  out  1  writes a register; 0 when rd is x0, or for branch/store
disp_v1  out  32  operand 1 value
disp_v2  out  32  operand 2 value
disp_q1  out  ROB_W  operand 1 dependency tag
disp_q2  out  ROB_W  operand 2 dependency tag
disp_has_q1  out  1  operand 1 is waiting on disp_q1
disp_has_q2  out  1  operand 2 is waiting on disp_q2
disp_imm  out  32  sign-extended immediate
disp_pc  out  32  instruction PC
disp_rob_id  out  ROB_W  ROB id assigned to this instruction
disp_pred_taken  out  1  branch predicted taken
disp_halt  out  1  instruction equals HALT_INST
redirect_valid  out  1  one-cycle fetch redirect
redirect_pc  out  32  redirect target

Behaviour:
Reset:
- All outputs and registers go to 0.
- Queue is empty, so fetch_ready=1 after reset.

Instruction queue:
- Circular FIFO with pointers of log2(IQ_DEPTH)+1 bits.
- fetch_ready = !full. A push happens on fetch_valid && fetch_ready.
- Push and pop in the same cycle are legal at any occupancy.

Dispatch condition (head present and all of):
- !rob_full.
- !rs_full for OP, OP-IMM and BRANCH.
- !lsb_full for LOAD and STORE.
- The other opcodes (LUI, AUIPC, JAL, JALR, halt) need the ROB only.
- On dispatch, the head pops and the disp_* registers load; disp_valid=1 for exactly that one cycle.

Operands:
- rs1/rs2 dependence comes from the rf_* inputs when the instruction actually uses that source; otherwise has_q=0 and v=0.
- Bypass: if disp_valid && disp_rd_we && disp_rd==rsN in the previous cycle, then has_qN=1 and qN=disp_rob_id, overriding the rf_* inputs.
- OP-IMM: v2 = sign-extended immI; for shifts v2 = shamt zero-extended.
- disp_rob_id = rob_tail.

Immediates:
- I/S/B/U/J formats per RV32I, sign-extended to 32 bits.
- AUIPC: disp_imm = pc+immU. JAL/JALR: disp_imm = pc+4.

Redirect:
- JAL dispatch: redirect_valid=1 and redirect_pc = pc+immJ in the same cycle as disp_valid.
- The queue is cleared that cycle; any push in that cycle is discarded.
- JALR: no redirect; the ROB resolves it.

Flush:
- flush has priority over push, pop and redirect.
- Queue empties and disp_valid=0 next cycle.
- Bypass history is cleared.

rdy low:
- No push, pop or state change.
- disp_valid and redirect_valid are gated low while rdy=0.

Halt:
- An instruction equal to HALT_INST dispatches with disp_unit=0 and disp_halt=1.

Optional Feature:
BRANCH_PREDICT_BTFN_EN
- Defined: a branch with negative immB is predicted taken; disp_pred_taken=1, and redirect_pc = pc+immB with the queue clear, exactly as for JAL.
- Undefined: all branches predicted not-taken; disp_pred_taken stays 0.

Decomposition:
- Shared package holds the opcode localparams, the disp_unit encodings (UNIT_ROB, UNIT_RS, UNIT_LSB) and HALT_INST.
- One sub-module, inst_queue: parametrised FIFO with flush.
- Decode, bypass and the output stage live in dispatch_decoder.

Test Plan:
1. addi x1,x0,5 at pc 0 with rob_tail=3 -> one cycle later disp_valid=1, unit=1, v2=5, rd=1, rob_id=3, has_q1=0.
2. addi x1,... then add x2,x1,x1 back-to-back, rf busy=0 -> second dispatch has has_q1=has_q2=1 and q1=q2=first rob_id.
3. jal x0,-8 at pc 0x100 with 2 younger entries queued -> redirect_valid=1, redirect_pc=0xF8, queue empty next cycle.
4. Fill IQ_DEPTH entries with lsb_full=1 at the head load -> fetch_ready=0, no disp_valid; drop lsb_full -> dispatch resumes in order.
5. flush asserted with the queue full and a push offered -> queue empty, disp_valid=0, fetch_ready=1 next cycle.
6. beq backward (immB=-16) at pc 0x40 -> with BRANCH_PREDICT_BTFN_EN: redirect_pc=0x30 and pred_taken=1; without it: no redirect.
